// File: rtl/if_stage.sv
// if_stage -- instruction-fetch stage of the pipelined MIPS datapath.
//
// Owns the program counter and the IF/ID pipeline register. Forms branch and
// jump targets from the ID-stage operands, selects the next PC, freezes on a
// load-use stall and flushes the wrong-path fetch on any redirect.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   stall          in   hold PC and IF/ID this cycle (wins over redirects)
//   branch_taken   in   conditional branch in ID resolved taken
//   branch_offset  in   sign-extended immediate, already << 2
//   id_pc_plus4    in   PC+4 of the instruction in ID (target base)
//   jump           in   j/jal in ID
//   jump_index     in   instr[25:0] of the jump
//   imem_rdata     in   instruction word at pc (combinational memory read)
//   pc             out  current fetch address
//   ifid_instr     out  registered instruction for ID
//   ifid_pc_plus4  out  registered PC+4 for ID
//   ifid_valid     out  1 = real instruction, 0 = bubble
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic [31:0] id_pc_plus4,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid
);

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  // All adds are modulo 2^32; carries are intentionally dropped so the PC
  // wraps from 0xFFFF_FFFC to 0 and branch targets wrap likewise.
  assign pc_plus4      = pc + 32'd4;
  assign branch_target = id_pc_plus4 + branch_offset;
  // Jump stays inside the 256 MB region of the instruction after the jump.
  assign jump_target   = {id_pc_plus4[31:28], jump_index, 2'b00};

  // Priority: reset > stall > jump > branch > sequential. Jump beats branch
  // so an illegal jump+branch combination still behaves deterministically.
  // A redirect discards the instruction fetched this cycle (no delay slot),
  // so IF/ID is loaded with an all-zero nop marked invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      ifid_instr    <= '0;
      ifid_pc_plus4 <= '0;
      ifid_valid    <= 1'b0;
    end else if (stall) begin
      pc            <= pc;
      ifid_instr    <= ifid_instr;
      ifid_pc_plus4 <= ifid_pc_plus4;
      ifid_valid    <= ifid_valid;
    end else if (jump) begin
      pc            <= jump_target;
      ifid_instr    <= '0;
      ifid_pc_plus4 <= '0;
      ifid_valid    <= 1'b0;
    end else if (branch_taken) begin
      pc            <= branch_target;
      ifid_instr    <= '0;
      ifid_pc_plus4 <= '0;
      ifid_valid    <= 1'b0;
    end else begin
      pc            <= pc_plus4;
      ifid_instr    <= imem_rdata;
      ifid_pc_plus4 <= pc_plus4;
      ifid_valid    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump;
  logic [31:0] branch_offset, id_pc_plus4;
  logic [25:0] jump_index;

  logic [31:0] pc0, instr0, p40, rd0;
  logic        v0;
  logic [31:0] pc1, instr1, p41, rd1;
  logic        v1;

  int nc = 0;
  int nf = 0;

  always #5 clk = ~clk;

  // instruction memory: word tagged with its own address
  assign rd0 = 32'h1000_0000 | pc0;
  assign rd1 = 32'h1000_0000 | pc1;

  if_stage #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .id_pc_plus4(id_pc_plus4), .jump(jump),
    .jump_index(jump_index), .imem_rdata(rd0), .pc(pc0), .ifid_instr(instr0),
    .ifid_pc_plus4(p40), .ifid_valid(v0));

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .id_pc_plus4(id_pc_plus4), .jump(jump),
    .jump_index(jump_index), .imem_rdata(rd1), .pc(pc1), .ifid_instr(instr1),
    .ifid_pc_plus4(p41), .ifid_valid(v1));

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    nc++;
    if (a !== e) begin
      nf++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // ---- behavioural model: one entry per DUT ----
  logic [31:0] m_pc [2];
  logic [31:0] m_ins[2];
  logic [31:0] m_p4 [2];
  logic        m_v  [2];
  logic [31:0] m_rst[2];
  bit          m_init = 0;

  initial begin
    m_rst[0] = 32'h0000_0000;
    m_rst[1] = 32'hFFFF_FFF8;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [31:0] seq;
      seq = m_pc[k] + 32'd4;
      if (reset) begin
        m_pc[k] = m_rst[k]; m_ins[k] = 0; m_p4[k] = 0; m_v[k] = 0;
      end else if (stall) begin
        // frozen
      end else if (jump || branch_taken) begin
        if (jump) m_pc[k] = {id_pc_plus4[31:28], jump_index, 2'b00};
        else      m_pc[k] = id_pc_plus4 + branch_offset;
        m_ins[k] = 0; m_p4[k] = 0; m_v[k] = 0;
      end else begin
        m_ins[k] = 32'h1000_0000 | m_pc[k];
        m_p4[k]  = seq;
        m_pc[k]  = seq;
        m_v[k]   = 1;
      end
    end
    if (reset) m_init = 1;
  end

  // ---- compare process: every cycle once the model is defined ----
  always @(negedge clk) begin
    if (m_init) begin
      chk("pc0",    pc0,    m_pc[0]);
      chk("instr0", instr0, m_ins[0]);
      chk("pc4_0",  p40,    m_p4[0]);
      chk("valid0", {31'b0, v0}, {31'b0, m_v[0]});
      chk("pc1",    pc1,    m_pc[1]);
      chk("instr1", instr1, m_ins[1]);
      chk("pc4_1",  p41,    m_p4[1]);
      chk("valid1", {31'b0, v1}, {31'b0, m_v[1]});
    end
  end

  task automatic cyc(input logic r, input logic s, input logic bt, input logic j,
                     input logic [31:0] off, input logic [31:0] ip4,
                     input logic [25:0] ji);
    reset = r; stall = s; branch_taken = bt; jump = j;
    branch_offset = off; id_pc_plus4 = ip4; jump_index = ji;
    @(negedge clk);
  endtask

  task automatic nop_cyc();
    cyc(0, 0, 0, 0, 32'h0, 32'h0, 26'h0);
  endtask

  logic [31:0] hold_pc, hold_ins;

  initial begin
    reset = 1; stall = 0; branch_taken = 0; jump = 0;
    branch_offset = 0; id_pc_plus4 = 0; jump_index = 0;
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rst_pc", pc0, 32'h0);
    chk("rst_instr", instr0, 32'h0);
    chk("rst_p4", p40, 32'h0);
    chk("rst_valid", {31'b0, v0}, 32'h0);
    chk("rst_pc1", pc1, 32'hFFFF_FFF8);

    // sequential fetch
    nop_cyc();
    chk("seq_pc4", pc0, 32'h4);
    chk("seq_instr0", instr0, 32'h1000_0000);
    chk("seq_valid", {31'b0, v0}, 32'h1);
    chk("wrap_pc_fffc", pc1, 32'hFFFF_FFFC);
    nop_cyc();
    chk("seq_pc8", pc0, 32'h8);
    chk("seq_instr4", instr0, 32'h1000_0004);
    chk("wrap_pc_0", pc1, 32'h0);
    chk("wrap_p4_0", p41, 32'h0);
    chk("wrap_instr", instr1, 32'hFFFF_FFFC);
    nop_cyc();
    chk("seq_pcC", pc0, 32'hC);

    // backward branch
    cyc(0, 0, 1, 0, 32'hFFFF_FFF0, 32'h20, 0);
    chk("br_pc", pc0, 32'h10);
    chk("br_bubble_v", {31'b0, v0}, 32'h0);
    chk("br_bubble_i", instr0, 32'h0);
    nop_cyc();
    chk("br_tgt_instr", instr0, 32'h1000_0010);
    chk("br_tgt_p4", p40, 32'h14);
    chk("br_tgt_v", {31'b0, v0}, 32'h1);

    // jump
    cyc(0, 0, 0, 1, 0, 32'h4000_0010, 26'h000_0040);
    chk("j_pc", pc0, 32'h4000_0100);
    chk("j_bubble", {31'b0, v0}, 32'h0);
    cyc(0, 0, 1, 1, 32'h100, 32'h20, 26'h10);
    chk("jb_pc", pc0, 32'h40);
    nop_cyc();
    nop_cyc();

    // stall with a pending branch
    hold_pc = pc0; hold_ins = instr0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 0, 32'h40, 32'h200, 0);
      chk("stall_pc", pc0, hold_pc);
      chk("stall_instr", instr0, hold_ins);
    end
    cyc(0, 0, 1, 0, 32'h40, 32'h200, 0);
    chk("stall_rel_pc", pc0, 32'h240);
    chk("stall_rel_v", {31'b0, v0}, 32'h0);

    // branch wrap-around
    cyc(0, 0, 1, 0, 32'h8, 32'hFFFF_FFFC, 0);
    chk("br_wrap", pc0, 32'h4);
    nop_cyc();

    // reset mid-stall and mid-redirect
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 32'h40, 32'h100, 0);
    chk("rst_stall_pc", pc0, 32'h0);
    chk("rst_stall_v", {31'b0, v0}, 32'h0);
    nop_cyc(); nop_cyc();
    cyc(1, 0, 1, 1, 32'h40, 32'h100, 26'h3);
    chk("rst_redir_pc", pc0, 32'h0);
    chk("rst_redir_i", instr0, 32'h0);
    chk("rst_redir_p4", p40, 32'h0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] off;
      off = ($urandom_range(0, 1) != 0) ? {{16{1'b1}}, 16'($urandom) & 16'hFFFC}
                                       : (32'($urandom_range(0, 255)) << 2);
      cyc($urandom_range(0, 99) < 2,
          $urandom_range(0, 99) < 20,
          $urandom_range(0, 99) < 15,
          $urandom_range(0, 99) < 10,
          off, $urandom, 26'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end
endmodule
